// File: rtl/cam_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture_pkg
//  Description : Shared types and widths for the camera capture block:
//                FSM state encoding, RGB565 pixel type, coordinate and
//                statistics counter widths, saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_capture_pkg;

    localparam int c_byte_w = 8;
    localparam int c_pix_w  = 16;
    localparam int c_x_w    = 10;
    localparam int c_y_w    = 9;
    localparam int c_stat_w = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_ACTIVE     = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Saturating +1 for the statistics counters
    function automatic logic [c_stat_w-1:0] sat_inc_stat(input logic [c_stat_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_capture_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture_sync
//  Description : Two-flop synchroniser for the raw sensor timing and data,
//                plus edge detection of pclk (rising), href (falling) and
//                vsync (rising and falling) on the synchronised samples.
//                All sensor signals share one synchroniser chain so the
//                href/vsync/data seen alongside a pclk edge belong to it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_capture_sync
    import cam_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_pclk,
    input  logic                i_href,
    input  logic                i_vsync,
    input  logic [c_byte_w-1:0] i_data,
    output logic                o_pclk_rise,
    output logic                o_href,
    output logic                o_vsync,
    output logic [c_byte_w-1:0] o_data,
    output logic                o_href_fall,
    output logic                o_vsync_rise,
    output logic                o_vsync_fall
);

    localparam int c_bus_w = c_byte_w + 3;

    logic [c_bus_w-1:0] w_raw;
    logic [c_bus_w-1:0] r_meta;
    logic [c_bus_w-1:0] r_sync;
    logic               r_pclk_d;
    logic               r_href_d;
    logic               r_vsync_d;

    assign w_raw = {i_pclk, i_href, i_vsync, i_data};

    // Two-stage synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta    <= '0;
            r_sync    <= '0;
            r_pclk_d  <= 1'b0;
            r_href_d  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_meta    <= w_raw;
            r_sync    <= r_meta;
            r_pclk_d  <= r_sync[c_bus_w-1];
            r_href_d  <= r_sync[c_bus_w-2];
            r_vsync_d <= r_sync[c_bus_w-3];
        end
    end

    assign o_pclk_rise  = r_sync[c_bus_w-1] & ~r_pclk_d;
    assign o_href       = r_sync[c_bus_w-2];
    assign o_vsync      = r_sync[c_bus_w-3];
    assign o_data       = r_sync[c_byte_w-1:0];
    assign o_href_fall  = ~r_sync[c_bus_w-2] & r_href_d;
    assign o_vsync_rise = r_sync[c_bus_w-3] & ~r_vsync_d;
    assign o_vsync_fall = ~r_sync[c_bus_w-3] & r_vsync_d;

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture
//  Description : Parallel camera (DVP) capture into an RGB565 pixel stream.
//                Generates the sensor master clock, synchronises the sensor
//                timing, assembles byte pairs into pixels with x/y
//                coordinates and presents them through a single output
//                register with valid/ready (sensor cannot be stalled, so a
//                pixel completing while the register is blocked is dropped).
//                Optional macro CAM_CAPTURE_STATS_EN adds saturating
//                frame_count / drop_count outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int XCLK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cam_pclk,
    input  logic                cam_href,
    input  logic                cam_vsync,
    input  logic [c_byte_w-1:0] cam_data,
    output logic                cam_xclk,
    input  logic                capture_en,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [c_pix_w-1:0]  pix_data,
    output logic [c_x_w-1:0]    pix_x,
    output logic [c_y_w-1:0]    pix_y,
    output logic                pix_sof,
`ifdef CAM_CAPTURE_STATS_EN
    output logic [c_stat_w-1:0] frame_count,
    output logic [c_stat_w-1:0] drop_count,
`endif
    output logic                busy
);

    localparam int                  c_xcnt_w    = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;
    localparam logic [c_xcnt_w-1:0] c_xcnt_last = c_xcnt_w'(XCLK_HALF - 1);
    localparam logic [c_x_w-1:0]    c_x_max     = c_x_w'(H_ACTIVE);
    localparam logic [c_y_w-1:0]    c_y_max     = c_y_w'(V_ACTIVE);

    // ------------------------------------------------------------------
    // Sensor master clock
    // ------------------------------------------------------------------
    logic [c_xcnt_w-1:0] r_xclk_cnt;
    logic                r_xclk;

    // Free-running divider: toggle cam_xclk every XCLK_HALF clk cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xclk_cnt <= '0;
            r_xclk     <= 1'b0;
        end else if (r_xclk_cnt == c_xcnt_last) begin
            r_xclk_cnt <= '0;
            r_xclk     <= ~r_xclk;
        end else begin
            r_xclk_cnt <= r_xclk_cnt + 1'b1;
        end
    end

    assign cam_xclk = r_xclk;

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    logic                w_pclk_rise;
    logic                w_href;
    logic                w_vsync;
    logic [c_byte_w-1:0] w_data;
    logic                w_href_fall;
    logic                w_vsync_rise;
    logic                w_vsync_fall;

    cam_capture_sync u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_pclk       (cam_pclk),
        .i_href       (cam_href),
        .i_vsync      (cam_vsync),
        .i_data       (cam_data),
        .o_pclk_rise  (w_pclk_rise),
        .o_href       (w_href),
        .o_vsync      (w_vsync),
        .o_data       (w_data),
        .o_href_fall  (w_href_fall),
        .o_vsync_rise (w_vsync_rise),
        .o_vsync_fall (w_vsync_fall)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    cap_state_t r_state;
    cap_state_t w_state_nxt;
    logic       w_busy;
    logic       w_frame_start;
    logic       w_frame_end;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: capture_en is only consulted at frame boundaries
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (capture_en && w_vsync) w_state_nxt = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (w_vsync_fall) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_vsync_rise) w_state_nxt = capture_en ? ST_WAIT_FRAME : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs and frame boundary strobes
    always_comb begin
        w_busy        = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_WAIT_FRAME: w_frame_start = w_vsync_fall;
            ST_ACTIVE: begin
                w_busy      = 1'b1;
                w_frame_end = w_vsync_rise;
            end
            default: ;
        endcase
    end

    assign busy = w_busy;

    // ------------------------------------------------------------------
    // Byte assembly and coordinate counters
    // ------------------------------------------------------------------
    logic [c_x_w-1:0]    r_x;
    logic [c_y_w-1:0]    r_y;
    logic                r_phase;
    logic [c_byte_w-1:0] r_hi;
    logic                w_byte_strobe;
    logic                w_pix_done;

    assign w_byte_strobe = w_busy & w_pclk_rise & w_href;
    assign w_pix_done    = w_byte_strobe & r_phase & (r_x < c_x_max) & (r_y < c_y_max);

    // Byte pairing, line/column tracking; counters saturate at the active size
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_hi    <= '0;
        end else if (w_frame_start) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
        end else if (w_busy) begin
            if (w_href_fall) begin
                // End of line: any unpaired byte is thrown away
                r_phase <= 1'b0;
                r_x     <= '0;
                if ((r_x != '0) && (r_y != c_y_max)) r_y <= r_y + 1'b1;
            end else if (w_byte_strobe) begin
                if (!r_phase) begin
                    r_hi    <= w_data;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (r_x != c_x_max) r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    rgb565_t          r_pix_data;
    logic [c_x_w-1:0] r_pix_x;
    logic [c_y_w-1:0] r_pix_y;
    logic             r_pix_valid;
    logic             r_pix_sof;
    logic             w_load;

    assign w_load = w_pix_done & (~r_pix_valid | pix_ready);

    // Single-entry pixel register: hold while stalled, reload on transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_data  <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_valid <= 1'b0;
            r_pix_sof   <= 1'b0;
        end else if (w_load) begin
            r_pix_data  <= {r_hi, w_data};
            r_pix_x     <= r_x;
            r_pix_y     <= r_y;
            r_pix_valid <= 1'b1;
            r_pix_sof   <= (r_x == '0) && (r_y == '0);
        end else if (r_pix_valid && pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_sof   <= 1'b0;
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_valid = r_pix_valid;
    assign pix_sof   = r_pix_sof;

`ifdef CAM_CAPTURE_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [c_stat_w-1:0] r_frame_count;
    logic [c_stat_w-1:0] r_drop_count;
    logic                w_drop;

    assign w_drop = w_pix_done & r_pix_valid & ~pix_ready;

    // Saturating frame-exit and backpressure-drop counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_frame_end) r_frame_count <= sat_inc_stat(r_frame_count);
            if (w_drop)      r_drop_count  <= sat_inc_stat(r_drop_count);
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line kept.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame kept.
REQ-003 SHALL have parameter XCLK_HALF, default 2, cam_xclk half-period in clk cycles (>=1).
REQ-004 Ports: clk  in  1  system clock; the block's only clock.
REQ-005 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: cam_pclk, cam_href, cam_vsync  in  1 each  raw sensor timing, asynchronous to clk.
REQ-007 Ports: cam_data  in  8  raw sensor byte.
REQ-008 Ports: cam_xclk  out  1  sensor master clock.
REQ-009 Ports: capture_en  in  1  capture request, sampled at frame boundaries only.
REQ-010 Ports: pix_valid out 1, pix_ready in 1, pix_data out 16 (RGB565), pix_x out 10, pix_y out 9, pix_sof out 1  pixel stream.
REQ-011 Ports: busy  out  1  high while state is ACTIVE.

Function
REQ-012 cam_xclk SHALL toggle every XCLK_HALF clk cycles, independent of capture state.
REQ-013 cam_pclk, cam_href, cam_vsync, cam_data SHALL pass a 2-flop synchroniser; pclk rising edge detected from synchronised samples; href/vsync/data used are those sampled with that edge.
REQ-014 Sensor pclk SHALL be <= clk/4; faster pclk is out of contract.
REQ-015 FSM states: IDLE, WAIT_FRAME, ACTIVE.
REQ-016 IDLE -> WAIT_FRAME when capture_en=1 and synchronised vsync=1.
REQ-017 WAIT_FRAME -> ACTIVE on synchronised vsync falling edge; x, y, byte phase cleared.
REQ-018 ACTIVE -> WAIT_FRAME on vsync rising edge if capture_en=1, else -> IDLE; deassertion of capture_en mid-frame SHALL NOT truncate the frame.
REQ-019 In ACTIVE, each pclk edge with href=1 stores a byte; first byte = pix_data[15:8], second = [7:0]; pixel completes on second byte.
REQ-020 On href falling edge in ACTIVE: pending odd byte discarded, phase=0, x=0, y increments if x was nonzero.
REQ-021 Pixels with x>=H_ACTIVE or y>=V_ACTIVE SHALL be dropped silently; counters saturate, never wrap.
REQ-022 Completed pixel SHALL appear with pix_valid=1 exactly one clk after the detected edge of its second byte.
REQ-023 pix_sof=1 only with pixel (0,0) of each frame.
REQ-024 Single output register: while pix_valid=1 and pix_ready=0, pix_* SHALL hold stable; a pixel completing then SHALL be dropped (sensor cannot stall).
REQ-025 Transfer occurs when pix_valid and pix_ready are both high; pix_valid clears next cycle unless a new pixel completes in that same cycle, in which case it is loaded.

Reset
REQ-026 On reset_n=0: state=IDLE; cam_xclk, pix_valid, pix_sof, busy=0; pix_data, pix_x, pix_y=0; counters and synchronisers cleared.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release capture resumes only via IDLE -> WAIT_FRAME -> ACTIVE.

Configuration
REQ-028 Macro CAM_CAPTURE_STATS_EN defined: extra outputs frame_count (16 bit, +1 per ACTIVE exit) and drop_count (16 bit, +1 per REQ-024 drop), both saturating, reset to 0.
REQ-029 Macro undefined: frame_count and drop_count ports absent; no counter logic synthesised.

Structure
REQ-030 Package cam_capture_pkg SHALL hold state enum, rgb565 typedef, coordinate widths.
REQ-031 Sub-module cam_capture_sync SHALL implement synchroniser and pclk/href/vsync edge detection.

Verification
REQ-032 Reset release, XCLK_HALF=2 -> cam_xclk period 4 clk; pix_valid=0; state IDLE.
REQ-033 capture_en=1, vsync pulse, 4x2 frame, bytes 0xF8,0x00,0x07,0xE0,... -> pixels 0xF800 (0,0,sof=1), 0x07E0 (1,0), ...; y=1 after href fall.
REQ-034 pix_ready=0 across two completed pixels -> first held stable, second dropped, drop_count=1.
REQ-035 Line of 645 pixels, H_ACTIVE=640 -> exactly 640 outputs, last pix_x=639.
REQ-036 href falls after 3 bytes -> one pixel out, third byte discarded; capture_en cleared mid-frame -> frame completes, then IDLE, busy=0.
